// File: rtl/conv_filter_sched_pkg.sv
// conv_filter_sched shared types and helpers
// state encoding, result width, clog2, tap slicing
package conv_filter_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // width of one ConvLayer_calc result
  function automatic int res_w(
    input int n,
    input int m,
    input int e
  );
    return n + m + e + 1;
  endfunction

  // ceiling log2, minimum 1 bit for v<=2
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // low bit of tap i in a packed bus of w-bit taps
  function automatic int tap_lo(
    input int i,
    input int w
  );
    return i * w;
  endfunction

endpackage

// File: rtl/conv_filter_sched_bank.sv
// conv_weight_bank: per-filter weight register file
// one write port, one async read port
module conv_weight_bank #(
  parameter int F  = 4,
  parameter int FW = 2,
  parameter int WW = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [FW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [FW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem [F];

  // slot write; out-of-range slots are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < F; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < F)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < F) ? mem[raddr] : '0;

endmodule

// File: rtl/conv_filter_sched.sv
// conv_filter_sched: shares one ConvLayer_calc across F filters
// holds a window, walks the weight bank, tags returning results
module conv_filter_sched
  import conv_filter_sched_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int E      = 3,
  parameter int F      = 4,
  parameter int FW     = clog2(F),
  parameter int OW     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          win_valid,
  input  logic [KERNEL*KERNEL*N-1:0]    win_data,
  output logic                          win_ready,
  input  logic                          wl_en,
  input  logic [FW-1:0]                 wl_idx,
  input  logic [KERNEL*KERNEL*M-1:0]    wl_data,
  output logic                          wl_err,
  output logic [KERNEL*KERNEL*N-1:0]    conv_data2conv,
  output logic [KERNEL*KERNEL*M-1:0]    conv_w,
  output logic                          conv_en_in,
  input  logic [res_w(N,M,E)-1:0]       conv_d_out,
  input  logic                          conv_en_out,
  output logic                          res_valid,
  output logic [res_w(N,M,E)-1:0]       res_data,
  output logic [FW-1:0]                 res_filt,
  output logic                          res_last,
  output logic                          busy
);

  localparam int KK = KERNEL * KERNEL;
  localparam logic [FW-1:0] FLAST = FW'(F - 1);

  state_t          state, state_n;
  logic [FW-1:0]   f_cnt, f_cnt_n;
  logic [FW-1:0]   out_cnt;
  logic [OW-1:0]   outst;
  logic [KK*N-1:0] win_q;
  logic            err_q;
  logic            win_ld;
  logic            bank_we;
  logic            rdy_c;
  logic            en_c;

  // next state, filter walk and handshake decode
  always_comb begin
    state_n = state;
    f_cnt_n = f_cnt;
    win_ld  = 1'b0;
    bank_we = 1'b0;
    rdy_c   = 1'b0;
    en_c    = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_c   = !wl_en;
        bank_we = wl_en;
        if (win_valid && !wl_en) begin
          win_ld  = 1'b1;
          f_cnt_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        en_c = 1'b1;
        if (f_cnt == FLAST) begin
          rdy_c = 1'b1;
          if (win_valid) begin
            win_ld  = 1'b1;
            f_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          f_cnt_n = f_cnt + 1'b1;
        end
      end
    endcase
  end

  // state and filter counter; f_cnt parks on F-1 in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      f_cnt <= '0;
    end else begin
      state <= state_n;
      f_cnt <= f_cnt_n;
    end
  end

  // window register, held across all F filter passes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else if (win_ld) win_q <= win_data;
  end

  // sticky error for weight writes attempted mid-window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (wl_en && (state == RUN)) err_q <= 1'b1;
  end

  // in-flight result count, floored at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= '0;
    end else begin
      unique case ({en_c, conv_en_out})
        2'b10: outst <= outst + 1'b1;
        2'b01: if (outst != '0) outst <= outst - 1'b1;
        default: ;
      endcase
    end
  end

  // result tag counter, wraps at F-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_cnt <= '0;
    else if (conv_en_out) out_cnt <= (out_cnt == FLAST) ? '0 : out_cnt + 1'b1;
  end

  conv_weight_bank #(
    .F  (F),
    .FW (FW),
    .WW (KK * M)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .waddr (wl_idx),
    .wdata (wl_data),
    .raddr (f_cnt),
    .rdata (conv_w)
  );

  assign conv_data2conv = win_q;
  assign conv_en_in     = en_c;
  assign win_ready      = rdy_c & ~rst;
  assign wl_err         = err_q;
  assign res_valid      = conv_en_out & ~rst;
  assign res_data       = rst ? '0 : conv_d_out;
  assign res_filt       = out_cnt;
  assign res_last       = (out_cnt == FLAST);
  assign busy           = (state == RUN) | (outst != '0);

endmodule

// File: tb/tb_conv_filter_sched.sv
// tb_conv_filter_sched: directed + random bench with a
// behavioural ConvLayer_calc and a per-filter scoreboard
module tb_conv_filter_sched;
  import conv_filter_sched_pkg::*;

  localparam int K   = 3;
  localparam int N   = 4;
  localparam int M   = 4;
  localparam int E   = 3;
  localparam int F   = 4;
  localparam int FW  = 2;
  localparam int OW  = 4;
  localparam int KK  = K * K;
  localparam int RW  = N + M + E + 1;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            win_valid;
  logic [KK*N-1:0] win_data;
  logic            win_ready;
  logic            wl_en;
  logic [FW-1:0]   wl_idx;
  logic [KK*M-1:0] wl_data;
  logic            wl_err;
  logic [KK*N-1:0] conv_data2conv;
  logic [KK*M-1:0] conv_w;
  logic            conv_en_in;
  logic [RW-1:0]   conv_d_out;
  logic            conv_en_out;
  logic            res_valid;
  logic [RW-1:0]   res_data;
  logic [FW-1:0]   res_filt;
  logic            res_last;
  logic            busy;

  conv_filter_sched #(
    .KERNEL (K), .N (N), .M (M), .E (E),
    .F (F), .FW (FW), .OW (OW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .win_valid      (win_valid),
    .win_data       (win_data),
    .win_ready      (win_ready),
    .wl_en          (wl_en),
    .wl_idx         (wl_idx),
    .wl_data        (wl_data),
    .wl_err         (wl_err),
    .conv_data2conv (conv_data2conv),
    .conv_w         (conv_w),
    .conv_en_in     (conv_en_in),
    .conv_d_out     (conv_d_out),
    .conv_en_out    (conv_en_out),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_filt       (res_filt),
    .res_last       (res_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int filt;
    bit last;
  } exp_t;

  exp_t q[$];
  int   bank_m [F][KK];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   en_cnt = 0;

  // behavioural ConvLayer_calc: dot product, fixed latency
  logic [LAT-1:0] pv = '0;
  logic [RW-1:0]  pd [LAT];

  function automatic logic [RW-1:0] dot(
    input logic [KK*N-1:0] d,
    input logic [KK*M-1:0] w
  );
    int s;
    s = 0;
    for (int i = 0; i < KK; i++)
      s += int'(d[tap_lo(i, N) +: N]) * int'(w[tap_lo(i, M) +: M]);
    return RW'(s);
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], conv_en_in};
    pd[0] <= dot(conv_data2conv, conv_w);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    cyc   <= cyc + 1;
  end

  assign conv_en_out = pv[LAT-1];
  assign conv_d_out  = pd[LAT-1];

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // result monitor against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (conv_en_in === 1'b1) en_cnt++;
    if (rst) begin
      chk("rst_res_valid", 64'(res_valid), 64'd0);
    end else if (res_valid !== 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(res_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_filt", 64'(res_filt), 64'(e.filt));
        chk("res_last", 64'(res_last), 64'(e.last));
      end
    end
  end

  function automatic logic [KK*N-1:0] fill(input int v);
    logic [KK*N-1:0] r;
    for (int i = 0; i < KK; i++) r[i*N +: N] = N'(v);
    return r;
  endfunction

  function automatic logic [KK*N-1:0] rvec();
    logic [KK*N-1:0] r;
    for (int i = 0; i < KK; i++) r[i*N +: N] = N'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic void push_exp(input logic [KK*N-1:0] d);
    int s;
    for (int f = 0; f < F; f++) begin
      s = 0;
      for (int i = 0; i < KK; i++) s += int'(d[i*N +: N]) * bank_m[f][i];
      q.push_back('{s, f, f == F - 1});
    end
  endfunction

  function automatic void set_bank(input int idx, input logic [KK*M-1:0] w);
    for (int i = 0; i < KK; i++) bank_m[idx][i] = int'(w[i*M +: M]);
  endfunction

  function automatic void clr_bank();
    for (int f = 0; f < F; f++)
      for (int i = 0; i < KK; i++) bank_m[f][i] = 0;
  endfunction

  // weight write in IDLE; called #1 after a rising edge
  task automatic wload(input int idx, input logic [KK*M-1:0] w);
    wl_en   = 1'b1;
    wl_idx  = FW'(idx);
    wl_data = w;
    @(posedge clk);
    #1;
    wl_en = 1'b0;
    set_bank(idx, w);
  endtask

  // offer a window, wait for acceptance, record expected results
  task automatic send(input logic [KK*N-1:0] d, output int acc);
    int n;
    n = 0;
    win_data  = d;
    win_valid = 1'b1;
    @(negedge clk);
    while (win_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("accept_timeout", 64'd0, 64'd1);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      push_exp(d);
    end
  endtask

  // wait for all results and idle, bounded
  task automatic drain();
    int n;
    n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int a0, a1, a2, e0, nw, slot;
    logic [KK*N-1:0] d;
    rst       = 1'b1;
    win_valid = 1'b0;
    win_data  = '0;
    wl_en     = 1'b0;
    wl_idx    = '0;
    wl_data   = '0;
    clr_bank();

    // reset values
    #12;
    chk("rst_win_ready", 64'(win_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wl_err", 64'(wl_err), 64'd0);
    chk("rst_en_in", 64'(conv_en_in), 64'd0);
    chk("rst_conv_w", 64'(conv_w), 64'd0);
    chk("rst_data2conv", 64'(conv_data2conv), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_win_ready", 64'(win_ready), 64'd1);

    // 1: bank[f] = f+1, window of ones
    for (int f = 0; f < F; f++) wload(f, fill(f + 1));
    e0 = en_cnt;
    send(fill(1), a0);
    win_valid = 1'b0;
    chk("t1_busy_run", 64'(busy), 64'd1);
    chk("t1_res0_expect", 64'(q[0].data), 64'd9);
    drain();
    chk("t1_en_cycles", 64'(en_cnt - e0), 64'd4);

    // 2: three back-to-back windows
    e0 = en_cnt;
    send(fill(1), a0);
    send(fill(2), a1);
    send(fill(3), a2);
    win_valid = 1'b0;
    chk("t2_gap1", 64'(a1 - a0), 64'(F));
    chk("t2_gap2", 64'(a2 - a1), 64'(F));
    drain();
    chk("t2_en_cycles", 64'(en_cnt - e0), 64'd12);

    // 3: weight write in 2nd RUN cycle is dropped
    send(rvec(), a0);
    win_valid = 1'b0;
    @(posedge clk);
    #1;
    wl_en   = 1'b1;
    wl_idx  = '0;
    wl_data = rvec();
    @(posedge clk);
    #1;
    wl_en = 1'b0;
    chk("t3_wl_err_set", 64'(wl_err), 64'd1);
    drain();
    send(rvec(), a0);
    win_valid = 1'b0;
    drain();
    chk("t3_wl_err_sticky", 64'(wl_err), 64'd1);

    // 4: weight write and window together in IDLE
    d         = rvec();
    wl_en     = 1'b1;
    wl_idx    = 2'd1;
    wl_data   = rvec();
    win_valid = 1'b1;
    win_data  = d;
    @(negedge clk);
    chk("t4_ready_blocked", 64'(win_ready), 64'd0);
    @(posedge clk);
    #1;
    set_bank(1, wl_data);
    wl_en = 1'b0;
    #1;
    chk("t4_ready_after", 64'(win_ready), 64'd1);
    chk("t4_not_taken", 64'(conv_en_in), 64'd0);
    @(posedge clk);
    #1;
    push_exp(d);
    win_valid = 1'b0;
    chk("t4_taken", 64'(conv_en_in), 64'd1);
    drain();

    // 5: async reset in the 3rd RUN cycle
    send(rvec(), a0);
    win_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    clr_bank();
    #1;
    chk("t5_en_in", 64'(conv_en_in), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_win_ready", 64'(win_ready), 64'd0);
    chk("t5_wl_err", 64'(wl_err), 64'd0);
    chk("t5_res_data", 64'(res_data), 64'd0);
    chk("t5_res_filt", 64'(res_filt), 64'd0);
    chk("t5_res_last", 64'(res_last), 64'd0);
    chk("t5_conv_w", 64'(conv_w), 64'd0);
    chk("t5_data2conv", 64'(conv_data2conv), 64'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_ready_release", 64'(win_ready), 64'd1);
    wload(0, fill(1));
    send(rvec(), a0);
    win_valid = 1'b0;
    drain();

    // 6: back-to-back weight writes to slots 3 and 2
    wload(3, rvec());
    wload(2, rvec());
    send(fill(1), a0);
    win_valid = 1'b0;
    drain();

    // random weight reloads and window bursts
    for (int it = 0; it < 8; it++) begin
      slot = $urandom_range(0, F - 1);
      wload(slot, rvec());
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) send(rvec(), a0);
      win_valid = 1'b0;
      drain();
    end
    chk("final_wl_err", 64'(wl_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
